// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and constants for the two-port SDRAM arbiter
package sdram_arb_pkg;

  localparam int DEF_HADDR_WIDTH = 24;
  localparam int DEF_DATA_WIDTH  = 16;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    ARB_S   = 2'd0,
    ISSUE_S = 2'd1,
    RUN_S   = 2'd2,
    DONE_S  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/sdram_arb_pick.sv
// rtl/sdram_arb_pick.sv - combinational 2-way winner pick (fixed priority under SDRAM_ARB_FIXED_PRIO_EN)
module sdram_arb_pick
  import sdram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  // Pick a winner; on a tie the port not served last wins unless fixed priority is built
  always_comb begin
    valid  = |req;
    winner = PORT0;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    winner = req[0] ? PORT0 : PORT1;
`else
    if (&req) begin
      winner = ~last;
    end else begin
      winner = req[0] ? PORT0 : PORT1;
    end
`endif
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-port arbiter in front of sdram_controller; SDRAM_ARB_FIXED_PRIO_EN selects fixed priority
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int HADDR_WIDTH = DEF_HADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   p0_req,
  input  logic                   p0_we,
  input  logic [HADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0]  p0_wdata,
  output logic                   p0_gnt,
  output logic                   p0_done,
  output logic [DATA_WIDTH-1:0]  p0_rdata,
  input  logic                   p1_req,
  input  logic                   p1_we,
  input  logic [HADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0]  p1_wdata,
  output logic                   p1_gnt,
  output logic                   p1_done,
  output logic [DATA_WIDTH-1:0]  p1_rdata,
  output logic [HADDR_WIDTH-1:0] ctl_rd_addr,
  output logic [HADDR_WIDTH-1:0] ctl_wr_addr,
  output logic [DATA_WIDTH-1:0]  ctl_wr_data,
  output logic                   ctl_rd_enable,
  output logic                   ctl_wr_enable,
  input  logic                   ctl_busy,
  input  logic                   ctl_rd_ready,
  input  logic [DATA_WIDTH-1:0]  ctl_rd_data
);

  arb_state_t             state, state_nx;
  logic                   owner_q, we_q;
  logic [HADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic                   en_q, en_nx, en_aged_q;
  logic                   rd_seen_q;
  logic [1:0]             gnt_q;
  logic                   last_q;
  logic                   pick_valid, pick_winner;
  logic                   take, rd_hit;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  assign last_q = PORT1;
`else
  // Round-robin pointer: remembers which port was granted most recently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= PORT1;
    end else if (take) begin
      last_q <= pick_winner;
    end
  end
`endif

  sdram_arb_pick u_pick (
    .req    ({p1_req, p0_req}),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // First read strobe of a read transaction in RUN; anything else is ignored
  assign rd_hit = (state == RUN_S) && !we_q && !rd_seen_q && ctl_rd_ready;

  // Next-state decode; the enable is only dropped on busy after it has been up two cycles
  always_comb begin
    state_nx = state;
    en_nx    = 1'b0;
    take     = 1'b0;
    case (state)
      ARB_S: begin
        if (pick_valid) begin
          take     = 1'b1;
          state_nx = ISSUE_S;
        end
      end
      ISSUE_S: begin
        en_nx = 1'b1;
        if (en_q && en_aged_q && ctl_busy) begin
          en_nx    = 1'b0;
          state_nx = RUN_S;
        end
      end
      RUN_S: begin
        if (!ctl_busy && (we_q || rd_seen_q || ctl_rd_ready)) begin
          state_nx = DONE_S;
        end
      end
      DONE_S: begin
        state_nx = ARB_S;
      end
      default: state_nx = ARB_S;
    endcase
  end

  // State, enable and grant registers plus request capture at grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_S;
      en_q      <= 1'b0;
      en_aged_q <= 1'b0;
      gnt_q     <= 2'b00;
      owner_q   <= PORT0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_seen_q <= 1'b0;
    end else begin
      state     <= state_nx;
      en_q      <= en_nx;
      en_aged_q <= en_q && en_nx;
      gnt_q     <= take ? (pick_winner ? 2'b10 : 2'b01) : 2'b00;
      if (take) begin
        owner_q   <= pick_winner;
        we_q      <= pick_winner ? p1_we : p0_we;
        addr_q    <= pick_winner ? p1_addr : p0_addr;
        wdata_q   <= pick_winner ? p1_wdata : p0_wdata;
        rd_seen_q <= 1'b0;
      end else if (rd_hit) begin
        rd_seen_q <= 1'b1;
      end
    end
  end

  // Per-port read data, held until that port's next read returns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else if (rd_hit) begin
      if (owner_q == PORT0) begin
        p0_rdata <= ctl_rd_data;
      end else begin
        p1_rdata <= ctl_rd_data;
      end
    end
  end

  assign p0_gnt        = gnt_q[0];
  assign p1_gnt        = gnt_q[1];
  assign p0_done       = (state == DONE_S) && (owner_q == PORT0);
  assign p1_done       = (state == DONE_S) && (owner_q == PORT1);
  assign ctl_rd_enable = en_q && !we_q;
  assign ctl_wr_enable = en_q && we_q;
  assign ctl_rd_addr   = addr_q;
  assign ctl_wr_addr   = addr_q;
  assign ctl_wr_data   = wdata_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed self-checking bench for sdram_port_arbiter
module tb_sdram_port_arbiter;

  localparam int AW = 24;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_gnt, p0_done, p1_gnt, p1_done;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] ctl_rd_addr, ctl_wr_addr;
  logic [DW-1:0] ctl_wr_data;
  logic          ctl_rd_enable, ctl_wr_enable;
  logic          ctl_busy, ctl_rd_ready;
  logic [DW-1:0] ctl_rd_data;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.HADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
    .ctl_rd_addr(ctl_rd_addr), .ctl_wr_addr(ctl_wr_addr), .ctl_wr_data(ctl_wr_data),
    .ctl_rd_enable(ctl_rd_enable), .ctl_wr_enable(ctl_wr_enable),
    .ctl_busy(ctl_busy), .ctl_rd_ready(ctl_rd_ready), .ctl_rd_data(ctl_rd_data)
  );

  // Controller model: accepts an enable only when idle and not refreshing,
  // busy rises one cycle after acceptance, read strobe mid-transaction
  logic [3:0]    m_cnt;
  logic          m_rd, m_busy, m_rdy;
  logic [4:0]    m_ref;
  logic          refresh_start, spur_rdy;
  logic [DW-1:0] model_data;
  int            accepts = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= '0; m_rd <= 1'b0; m_busy <= 1'b0; m_rdy <= 1'b0; m_ref <= '0;
    end else begin
      m_busy <= (m_cnt != 0);
      m_rdy  <= m_rd && (m_cnt == 4'd3);
      if (refresh_start) m_ref <= 5'd20;
      else if (m_ref != 0) m_ref <= m_ref - 5'd1;
      else if (m_cnt == 0 && !m_busy && (ctl_rd_enable || ctl_wr_enable)) begin
        m_cnt   <= 4'd6;
        m_rd    <= ctl_rd_enable;
        accepts <= accepts + 1;
      end else if (m_cnt != 0) m_cnt <= m_cnt - 4'd1;
    end
  end

  assign ctl_busy     = m_busy;
  assign ctl_rd_ready = m_rdy | spur_rdy;
  assign ctl_rd_data  = model_data;

  // Pulse counters, grant order and busy history sampled on the falling edge
  int   gnt0 = 0, gnt1 = 0, done0 = 0, done1 = 0, en_cycles = 0;
  int   grant_log[$];
  logic busy_d1 = 1'b0, busy_d2 = 1'b0;
  logic [2:0] done_bh = 3'b000;

  always @(negedge clk) begin
    if (p0_gnt) begin gnt0++; grant_log.push_back(0); end
    if (p1_gnt) begin gnt1++; grant_log.push_back(1); end
    if (p0_done) done0++;
    if (p1_done) done1++;
    if (ctl_rd_enable || ctl_wr_enable) en_cycles++;
    if (p0_done || p1_done) done_bh = {busy_d2, busy_d1, ctl_busy};
    busy_d2 = busy_d1;
    busy_d1 = ctl_busy;
  end

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  task automatic wait_done(input logic port, input string tag);
    int k = 0;
    while (((port ? p1_done : p0_done) !== 1'b1) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_seen"}, 32'(k < 100), 1);
    #1;
  endtask

  task automatic wait_busy(input string tag);
    int k = 0;
    while (ctl_busy !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_busy_seen"}, 32'(k < 60), 1);
  endtask

  int e0, a0, d0, d1, g0;
  int exp_order[4];

  initial begin
    rst_n = 1'b0; p0_req = 0; p0_we = 0; p1_req = 0; p1_we = 0;
    p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
    refresh_start = 0; spur_rdy = 0; model_data = '0;
    repeat (2) @(negedge clk);
    check("rst_pulses", {p1_gnt, p0_gnt, p1_done, p0_done, ctl_wr_enable, ctl_rd_enable}, 6'b0);
    check("rst_rdata", {p1_rdata, p0_rdata}, 32'h0);
    check("rst_addr", ctl_rd_addr, 24'h0);
    rst_n = 1'b1;

    // single read on port 0
    @(negedge clk);
    e0 = en_cycles;
    model_data = 16'hBEEF; p0_req = 1; p0_we = 0; p0_addr = 24'h012345;
    @(negedge clk);
    check("t1_gnt", {p1_gnt, p0_gnt}, 2'b01);
    p0_req = 0;
    @(negedge clk);
    check("t1_en", {ctl_wr_enable, ctl_rd_enable}, 2'b01);
    check("t1_addr", ctl_rd_addr, 24'h012345);
    wait_done(1'b0, "t1");
    check("t1_rdata", p0_rdata, 16'hBEEF);
    check("t1_en_off", ctl_rd_enable, 0);
    check("t1_en_cycles", en_cycles - e0, 3);
    check("t1_busy_hist", done_bh, 3'b100);
    check("t1_p1_silent", {gnt1[7:0], done1[7:0], p1_rdata}, 32'h0);
    @(negedge clk);
    check("t1_done_1cyc", p0_done, 0);
    check("t1_rdata_hold", p0_rdata, 16'hBEEF);

    // single write on port 1
    model_data = 16'h5555; p1_req = 1; p1_we = 1; p1_addr = 24'h000100; p1_wdata = 16'hA5A5;
    @(negedge clk);
    check("t2_gnt", {p1_gnt, p0_gnt}, 2'b10);
    p1_req = 0;
    @(negedge clk);
    check("t2_en", {ctl_wr_enable, ctl_rd_enable}, 2'b10);
    check("t2_wdata", ctl_wr_data, 16'hA5A5);
    check("t2_waddr", ctl_wr_addr, 24'h000100);
    wait_done(1'b1, "t2");
    check("t2_busy_hist", done_bh, 3'b100);
    check("t2_done_cnt", done1, 1);
    check("t2_p0_rdata", p0_rdata, 16'hBEEF);

    // both ports requesting continuously
    @(negedge clk);
    g0 = grant_log.size();
    model_data = 16'h3C3C;
    p0_req = 1; p0_we = 0; p0_addr = 24'h000200;
    p1_req = 1; p1_we = 1; p1_addr = 24'h000300; p1_wdata = 16'h0F0F;
    for (int k = 0; k < 200 && grant_log.size() < g0 + 4; k++) @(negedge clk);
    p0_req = 0; p1_req = 0;
    repeat (30) @(negedge clk);
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    check("t3_grant_cnt", grant_log.size() - g0, 4);
    for (int i = 0; i < 4; i++)
      if (grant_log.size() > g0 + i) check($sformatf("t3_order%0d", i), grant_log[g0 + i], exp_order[i]);

    // request during controller refresh
    refresh_start = 1;
    @(negedge clk);
    refresh_start = 0;
    a0 = accepts; d0 = done0; e0 = en_cycles;
    model_data = 16'h7E57; p0_req = 1; p0_we = 0; p0_addr = 24'h000400;
    @(negedge clk);
    check("t4_gnt", p0_gnt, 1);
    p0_req = 0;
    wait_done(1'b0, "t4");
    check("t4_accepts", accepts - a0, 1);
    check("t4_done_cnt", done0 - d0, 1);
    check("t4_en_held", 32'((en_cycles - e0) >= 20), 1);
    check("t4_rdata", p0_rdata, 16'h7E57);

    // reset asserted while in RUN
    @(negedge clk);
    model_data = 16'h1111; p0_req = 1; p0_we = 0; p0_addr = 24'h000500;
    @(negedge clk);
    p0_req = 0;
    wait_busy("t5");
    @(negedge clk);
    d0 = done0;
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_pulses", {p1_gnt, p0_gnt, p1_done, p0_done, ctl_wr_enable, ctl_rd_enable}, 6'b0);
    check("t5_rst_rdata", p0_rdata, 16'h0);
    check("t5_rst_addr", ctl_rd_addr, 24'h0);
    repeat (3) @(negedge clk);
    check("t5_no_done", done0 - d0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    model_data = 16'h2222; d1 = done1;
    p0_req = 1; p0_we = 0; p0_addr = 24'h000600;
    p1_req = 1; p1_we = 0; p1_addr = 24'h000700;
    @(negedge clk);
    check("t5_tie_gnt", {p1_gnt, p0_gnt}, 2'b01);
    p0_req = 0; p1_req = 0;
    wait_done(1'b0, "t5");
    check("t5_rdata", p0_rdata, 16'h2222);

    // spurious read strobes in idle and during a write
    @(negedge clk);
    model_data = 16'hDEAD; spur_rdy = 1;
    @(negedge clk);
    spur_rdy = 0;
    d0 = done0;
    p0_req = 1; p0_we = 1; p0_addr = 24'h000800; p0_wdata = 16'h9999;
    @(negedge clk);
    p0_req = 0;
    wait_busy("t6");
    @(negedge clk);
    spur_rdy = 1;
    @(negedge clk);
    spur_rdy = 0;
    wait_done(1'b0, "t6");
    repeat (5) @(negedge clk);
    check("t6_rdata0", p0_rdata, 16'h2222);
    check("t6_rdata1", p1_rdata, 16'h0);
    check("t6_done_cnt", done0 - d0, 1);
    check("t6_p1_no_done", done1 - d1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
